// File: rtl/mx_block_serializer.sv
// mx_block_serializer: buffers one MX block and streams it as k/lanes beats; MX_BLOCK_SERIALIZER_PERF_EN adds perf counters
module mx_block_serializer #(
    parameter int exp_width = 3,
    parameter int man_width = 2,
    parameter int bit_width = 1 + exp_width + man_width,
    parameter int k         = 32,
    parameter int lanes     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [bit_width-1:0]       i_mx_vec [k],
    input  logic [7:0]                 i_mx_exp,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [lanes*bit_width-1:0] o_data,
    output logic [7:0]                 o_mx_exp,
    output logic                       o_first,
    output logic                       o_last
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
    ,
    output logic [31:0]                o_blk_cnt,
    output logic [31:0]                o_stall_cnt,
    output logic [31:0]                o_nan_cnt
`endif
);
    localparam int beats = k / lanes;
    localparam int cw = beats > 1 ? $clog2(beats) : 1;
    localparam int slots = 1 << cw;
    localparam int bw = lanes * bit_width;
    localparam logic [cw-1:0] last_cnt = cw'(beats - 1);

    typedef enum logic {IDLE, SEND} state_t;

    if (lanes < 1 || lanes > k || k % lanes != 0) begin : g_bad_cfg
        $error("mx_block_serializer: k must be a multiple of lanes with 1 <= lanes <= k");
    end

    state_t               state_q, state_d;
    logic [bit_width-1:0] buf_q [k];
    logic [bit_width-1:0] buf_d [k];
    logic [cw-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [bw-1:0]        data_q, data_d, in_beat0;
    logic [7:0]           exp_q, exp_d;
    logic                 first_q, first_d, last_q, last_d;
    logic [bw-1:0]        buf_beat [slots];
    logic                 accept, hs;

    genvar b, j;
    for (b = 0; b < slots; b++) begin : g_slot
        for (j = 0; j < lanes; j++) begin : g_lane
            if (b < beats) begin : g_used
                assign buf_beat[b][j*bit_width +: bit_width] = buf_q[b*lanes+j];
            end else begin : g_pad
                assign buf_beat[b][j*bit_width +: bit_width] = '0;
            end
        end
    end

    for (j = 0; j < lanes; j++) begin : g_in0
        assign in_beat0[j*bit_width +: bit_width] = i_mx_vec[j];
    end

    assign accept  = i_valid && o_ready;
    assign hs      = (state_q == SEND) && i_ready;
    assign cnt_inc = cnt_q + 1'b1;
    assign o_ready = !i_rst && (state_q == IDLE || (last_q && i_ready));

    // accept a block (also on the last-beat handshake), advance a beat, or fall idle
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        exp_d   = exp_q;
        first_d = first_q;
        last_d  = last_q;
        if (accept) begin
            state_d = SEND;
            buf_d   = i_mx_vec;
            cnt_d   = '0;
            data_d  = in_beat0;
            exp_d   = i_mx_exp;
            first_d = 1'b1;
            last_d  = beats == 1;
        end else if (hs && !last_q) begin
            cnt_d   = cnt_inc;
            data_d  = buf_beat[cnt_inc];
            first_d = 1'b0;
            last_d  = cnt_inc == last_cnt;
        end else if (hs) begin
            state_d = IDLE;
            first_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // control and output registers; reset drops any block in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            exp_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            exp_q   <= exp_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // block buffer holds no meaningful reset value
    always_ff @(posedge i_clk) begin
        buf_q <= buf_d;
    end

    assign o_valid  = state_q == SEND;
    assign o_data   = data_q;
    assign o_mx_exp = exp_q;
    assign o_first  = first_q;
    assign o_last   = last_q;

`ifdef MX_BLOCK_SERIALIZER_PERF_EN
    logic [31:0] blk_q, blk_d, stall_q, stall_d, nan_q, nan_d;

    // completed blocks, stalled cycles and accepted NaN blocks, wrapping
    always_comb begin
        blk_d   = blk_q + 32'(hs && last_q);
        stall_d = stall_q + 32'(o_valid && !i_ready);
        nan_d   = nan_q + 32'(accept && i_mx_exp == 8'hff);
    end

    // perf counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blk_q   <= '0;
            stall_q <= '0;
            nan_q   <= '0;
        end else begin
            blk_q   <= blk_d;
            stall_q <= stall_d;
            nan_q   <= nan_d;
        end
    end

    assign o_blk_cnt   = blk_q;
    assign o_stall_cnt = stall_q;
    assign o_nan_cnt   = nan_q;
`endif
endmodule

// File: tb/tb_mx_block_serializer.sv
// tb_mx_block_serializer: randomized scoreboard bench for mx_block_serializer
module tb_mx_block_serializer;
    localparam int W = 6, K = 32, L = 8, B = K / L, BW = L * W, K1 = 8;

    typedef struct packed {logic [K*W-1:0] v; logic [7:0] e; int c;} acc_t;
    typedef struct packed {logic [BW-1:0] d; logic [7:0] e; logic f; logic l; int c;} beat_t;

    logic clk = 0, rst = 1, in_valid = 0, in_ready = 1;
    logic [W-1:0] vec [K];
    logic [7:0] exp_in = 0;
    logic [K*W-1:0] cur_flat = 0;
    logic o_ready, o_valid, o_first, o_last;
    logic [BW-1:0] o_data;
    logic [7:0] o_mx_exp;

    logic valid1 = 0, ready1 = 1;
    logic [W-1:0] vec1 [K1];
    logic [7:0] exp1 = 0;
    logic o_ready1, o_valid1, o_first1, o_last1;
    logic [K1*W-1:0] o_data1;
    logic [7:0] o_mx_exp1;

`ifdef MX_BLOCK_SERIALIZER_PERF_EN
    logic [31:0] blk_cnt, stall_cnt, nan_cnt, blk_cnt1, stall_cnt1, nan_cnt1;
`endif

    int n_cmp = 0, n_err = 0, cyc = 0;
    acc_t acc_q[$];
    beat_t obs_q[$];

    always #5 clk = ~clk;

    mx_block_serializer #(.exp_width(3), .man_width(2), .k(K), .lanes(L)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(o_ready),
        .i_mx_vec(vec), .i_mx_exp(exp_in), .o_valid(o_valid), .i_ready(in_ready),
        .o_data(o_data), .o_mx_exp(o_mx_exp), .o_first(o_first), .o_last(o_last)
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
        , .o_blk_cnt(blk_cnt), .o_stall_cnt(stall_cnt), .o_nan_cnt(nan_cnt)
`endif
    );

    mx_block_serializer #(.exp_width(3), .man_width(2), .k(K1), .lanes(K1)) u_one (
        .i_clk(clk), .i_rst(rst), .i_valid(valid1), .o_ready(o_ready1),
        .i_mx_vec(vec1), .i_mx_exp(exp1), .o_valid(o_valid1), .i_ready(ready1),
        .o_data(o_data1), .o_mx_exp(o_mx_exp1), .o_first(o_first1), .o_last(o_last1)
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
        , .o_blk_cnt(blk_cnt1), .o_stall_cnt(stall_cnt1), .o_nan_cnt(nan_cnt1)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    // record input accepts and output beat handshakes just before each rising edge
    always @(negedge clk) begin
        #4;
        if (!rst && in_valid && o_ready) acc_q.push_back('{cur_flat, exp_in, cyc});
        if (!rst && o_valid && in_ready) obs_q.push_back('{o_data, o_mx_exp, o_first, o_last, cyc});
    end

    function automatic logic [K*W-1:0] rand_flat();
        logic [K*W-1:0] r;
        for (int i = 0; i < K; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic set_block(input logic [K*W-1:0] f, input logic [7:0] e);
        cur_flat = f;
        exp_in = e;
        for (int i = 0; i < K; i++) vec[i] = f[i*W +: W];
    endtask

    task automatic send(input int n, input bit rnd, input bit gaps, input bit fixed,
                        input logic [K*W-1:0] f0, input logic [7:0] e0);
        logic [K*W-1:0] f;
        logic [7:0] e;
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 0;
                    if (rnd) in_ready = 1'($urandom);
                    @(negedge clk);
                end
            end
            f = !fixed ? rand_flat() : (i % 2 == 0) ? f0 : ~f0;
            e = !fixed ? (($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom)) : e0 + 8'(i);
            set_block(f, e);
            in_valid = 1;
            if (rnd) in_ready = 1'($urandom);
            for (int t = 0; ; t++) begin
                #4 acc = o_ready;
                @(negedge clk);
                if (acc) break;
                if (t > 300) begin
                    n_cmp++; n_err++;
                    $display("FAIL send_timeout block %0d never accepted (o_ready=%b)", i, o_ready);
                    break;
                end
                if (rnd) in_ready = 1'($urandom);
            end
        end
        in_valid = 0;
    endtask

    task automatic drain(input bit rnd);
        for (int t = 0; ; t++) begin
            if (!o_valid) break;
            if (t > 300) begin
                n_cmp++; n_err++;
                $display("FAIL drain_timeout o_valid=%b still high after %0d cycles", o_valid, t);
                break;
            end
            in_ready = rnd ? 1'($urandom) : 1'b1;
            @(negedge clk);
        end
        in_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_ready = 1; valid1 = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", o_valid); end
        n_cmp++; if ({o_first, o_last} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b want 00", {o_first, o_last}); end
        n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL rst_data got %h want 0", o_data); end
        n_cmp++; if (o_mx_exp !== 8'h00) begin n_err++; $display("FAIL rst_exp got %h want 00", o_mx_exp); end
        n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_in_reset got %b want 0", o_ready); end
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
        n_cmp++; if ({blk_cnt, stall_cnt, nan_cnt} !== 96'd0) begin n_err++; $display("FAIL rst_perf got %0d/%0d/%0d want 0/0/0", blk_cnt, stall_cnt, nan_cnt); end
`endif
        rst = 0;
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_idle got %b want 1", o_ready); end
        n_cmp++; if (o_valid1 !== 1'b0 || o_ready1 !== 1'b1) begin n_err++; $display("FAIL rst_one got valid=%b ready=%b want 0/1", o_valid1, o_ready1); end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [K*W-1:0] f;
        logic [BW+9:0] got, want;
        acc_q.delete(); obs_q.delete();
        for (int i = 0; i < K; i++) f[i*W +: W] = W'(i % 64);
        send(1, 0, 0, 1, f, 8'h7d);
        drain(0);
        n_cmp++; if (acc_q.size() !== 1 || obs_q.size() !== B) begin n_err++; $display("FAIL single_count got %0d blocks %0d beats want 1 %0d", acc_q.size(), obs_q.size(), B); end
        foreach (acc_q[a]) for (int b = 0; b < B; b++) if (a * B + b < obs_q.size()) begin
            got  = {obs_q[a*B+b].d, obs_q[a*B+b].e, obs_q[a*B+b].f, obs_q[a*B+b].l};
            want = {acc_q[a].v[b*BW +: BW], acc_q[a].e, b == 0, b == B - 1};
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL single_beat%0d got %h want %h", b, got, want); end
            n_cmp++; if (obs_q[a*B+b].c !== acc_q[a].c + 1 + b) begin n_err++; $display("FAIL single_timing%0d got cycle %0d want %0d", b, obs_q[a*B+b].c, acc_q[a].c + 1 + b); end
        end
    endtask

    task automatic test_back_to_back();
        logic [BW+9:0] got, want;
        acc_q.delete(); obs_q.delete();
        send(2, 0, 0, 1, rand_flat(), 8'h21);
        drain(0);
        n_cmp++; if (acc_q.size() !== 2 || obs_q.size() !== 2 * B) begin n_err++; $display("FAIL b2b_count got %0d blocks %0d beats want 2 %0d", acc_q.size(), obs_q.size(), 2 * B); end
        foreach (acc_q[a]) for (int b = 0; b < B; b++) if (a * B + b < obs_q.size()) begin
            got  = {obs_q[a*B+b].d, obs_q[a*B+b].e, obs_q[a*B+b].f, obs_q[a*B+b].l};
            want = {acc_q[a].v[b*BW +: BW], acc_q[a].e, b == 0, b == B - 1};
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL b2b_blk%0d_beat%0d got %h want %h", a, b, got, want); end
        end
        if (acc_q.size() == 2 && obs_q.size() == 2 * B) begin
            for (int i = 0; i < 2 * B; i++) begin
                n_cmp++; if (obs_q[i].c !== acc_q[0].c + 1 + i) begin n_err++; $display("FAIL b2b_bubble beat%0d got cycle %0d want %0d", i, obs_q[i].c, acc_q[0].c + 1 + i); end
            end
            n_cmp++; if (acc_q[1].c !== obs_q[B-1].c) begin n_err++; $display("FAIL b2b_accept got cycle %0d want %0d", acc_q[1].c, obs_q[B-1].c); end
        end
    endtask

    task automatic test_stall();
        logic [K*W-1:0] f;
        logic [BW+9:0] got, want;
        int s0;
        acc_q.delete(); obs_q.delete();
        s0 = 0;
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
        s0 = int'(stall_cnt);
`endif
        f = rand_flat();
        set_block(f, 8'h44);
        in_valid = 1; in_ready = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        in_ready = 0;
        want = {f[BW +: BW], 8'h44, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) in_ready = 1;
            #1;
            got = {o_data, o_mx_exp, o_first, o_last};
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL stall_hold%0d got %h want %h", i, got, want); end
            n_cmp++; if ({o_valid, o_ready} !== 2'b10) begin n_err++; $display("FAIL stall_hs%0d got valid/ready %b want 10", i, {o_valid, o_ready}); end
            if (i < 3) @(negedge clk);
        end
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
        n_cmp++; if (int'(stall_cnt) - s0 !== 3) begin n_err++; $display("FAIL stall_cnt got %0d want 3", int'(stall_cnt) - s0); end
`endif
        @(negedge clk);
        drain(0);
        n_cmp++; if (acc_q.size() !== 1 || obs_q.size() !== B) begin n_err++; $display("FAIL stall_count got %0d blocks %0d beats want 1 %0d", acc_q.size(), obs_q.size(), B); end
        foreach (acc_q[a]) for (int b = 0; b < B; b++) if (a * B + b < obs_q.size()) begin
            got  = {obs_q[a*B+b].d, obs_q[a*B+b].e, obs_q[a*B+b].f, obs_q[a*B+b].l};
            want = {acc_q[a].v[b*BW +: BW], acc_q[a].e, b == 0, b == B - 1};
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL stall_beat%0d got %h want %h", b, got, want); end
        end
    endtask

    task automatic test_reset_mid();
        logic [K*W-1:0] f;
        logic [BW+9:0] got, want;
        acc_q.delete(); obs_q.delete();
        f = rand_flat();
        send(1, 0, 0, 1, f, 8'h55);
        for (int t = 0; obs_q.size() < 2; t++) begin
            if (t > 20) begin n_cmp++; n_err++; $display("FAIL rstmid_timeout got %0d beats want 2", obs_q.size()); break; end
            @(negedge clk);
        end
        n_cmp++; if (o_data !== f[2*BW +: BW]) begin n_err++; $display("FAIL rstmid_beat2 got %h want %h", o_data, f[2*BW +: BW]); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        n_cmp++; if ({o_valid, o_ready, o_first} !== 3'b010) begin n_err++; $display("FAIL rstmid_idle got valid/ready/first %b want 010", {o_valid, o_ready, o_first}); end
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
        n_cmp++; if ({blk_cnt, nan_cnt} !== 64'd0) begin n_err++; $display("FAIL rstmid_perf got blk %0d nan %0d want 0 0", blk_cnt, nan_cnt); end
`endif
        @(negedge clk);
        acc_q.delete(); obs_q.delete();
        send(1, 0, 0, 1, rand_flat(), 8'hff);
        drain(0);
        n_cmp++; if (acc_q.size() !== 1 || obs_q.size() !== B) begin n_err++; $display("FAIL rstmid_count got %0d blocks %0d beats want 1 %0d", acc_q.size(), obs_q.size(), B); end
        foreach (acc_q[a]) for (int b = 0; b < B; b++) if (a * B + b < obs_q.size()) begin
            got  = {obs_q[a*B+b].d, obs_q[a*B+b].e, obs_q[a*B+b].f, obs_q[a*B+b].l};
            want = {acc_q[a].v[b*BW +: BW], 8'hff, b == 0, b == B - 1};
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL rstmid_beat%0d got %h want %h", b, got, want); end
        end
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
        n_cmp++; if ({blk_cnt, nan_cnt} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL rstmid_perf_after got blk %0d nan %0d want 1 1", blk_cnt, nan_cnt); end
`endif
    endtask

    task automatic test_single_beat();
        logic [K1*W-1:0] f;
        valid1 = 1; ready1 = 1;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < K1; i++) f[i*W +: W] = W'($urandom);
            for (int i = 0; i < K1; i++) vec1[i] = f[i*W +: W];
            exp1 = 8'(n + 8'h30);
            #4;
            n_cmp++; if (o_ready1 !== 1'b1) begin n_err++; $display("FAIL one_ready%0d got %b want 1", n, o_ready1); end
            @(negedge clk);
            n_cmp++; if ({o_valid1, o_first1, o_last1} !== 3'b111) begin n_err++; $display("FAIL one_flags%0d got %b want 111", n, {o_valid1, o_first1, o_last1}); end
            n_cmp++; if ({o_data1, o_mx_exp1} !== {f, 8'(n + 8'h30)}) begin n_err++; $display("FAIL one_data%0d got %h want %h", n, {o_data1, o_mx_exp1}, {f, 8'(n + 8'h30)}); end
        end
        valid1 = 0;
        @(negedge clk);
        n_cmp++; if (o_valid1 !== 1'b0) begin n_err++; $display("FAIL one_idle got %b want 0", o_valid1); end
    endtask

    task automatic test_random();
        logic [BW+9:0] got, want;
        int b0, n0, nn;
        acc_q.delete(); obs_q.delete();
        b0 = 0; n0 = 0; nn = 0;
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
        b0 = int'(blk_cnt); n0 = int'(nan_cnt);
`endif
        send(12, 1, 1, 0, '0, 8'h00);
        drain(1);
        n_cmp++; if (acc_q.size() !== 12 || obs_q.size() !== 12 * B) begin n_err++; $display("FAIL rand_count got %0d blocks %0d beats want 12 %0d", acc_q.size(), obs_q.size(), 12 * B); end
        foreach (acc_q[a]) begin
            if (acc_q[a].e == 8'hff) nn++;
            for (int b = 0; b < B; b++) if (a * B + b < obs_q.size()) begin
                got  = {obs_q[a*B+b].d, obs_q[a*B+b].e, obs_q[a*B+b].f, obs_q[a*B+b].l};
                want = {acc_q[a].v[b*BW +: BW], acc_q[a].e, b == 0, b == B - 1};
                n_cmp++; if (got !== want) begin n_err++; $display("FAIL rand_blk%0d_beat%0d got %h want %h", a, b, got, want); end
            end
        end
`ifdef MX_BLOCK_SERIALIZER_PERF_EN
        n_cmp++; if (int'(blk_cnt) - b0 !== 12) begin n_err++; $display("FAIL rand_blk_cnt got %0d want 12", int'(blk_cnt) - b0); end
        n_cmp++; if (int'(nan_cnt) - n0 !== nn) begin n_err++; $display("FAIL rand_nan_cnt got %0d want %0d", int'(nan_cnt) - n0, nn); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_single_beat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
